uart_tx_arbiter: RTL and testbench

- Shares the single uart_tx transmitter between NUM_REQ byte producers, for example termbuffer echo output and a status/banner generator.
- Grants one byte at a time using round-robin priority.
- Launches the byte with a one-cycle DV pulse, then tracks the uart_tx Active/Done outputs until the frame completes.
- Sits between the producers and uart_tx in hwterm_top; its o_tx_dv/o_tx_byte replace the direct termbuffer→uart_tx connection.

---
 rtl/uart_tx_arbiter.sv | 112 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among NUM_REQ byte producers; define TXARB_TIMEOUT_EN for the watchdog
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 480000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_byte,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       o_tx_dv,
  output logic [7:0]                 o_tx_byte,
  input  logic                       i_tx_active,
  input  logic                       i_tx_done,
  output logic                       o_busy,
  output logic [$clog2(NUM_REQ)-1:0] o_grant,
  output logic                       o_timeout
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_ACTIVE, WAIT_DONE, GAP} state_t;
  state_t        state_q, state_d;
  logic [IW-1:0] last_grant_q, last_grant_d, grant_q, grant_d, pick, idx;
  logic [7:0]    byte_q, byte_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          found, accept, timeout;
  // round-robin scan starting just after the last granted requester
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((int'(last_grant_q) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end
  assign accept    = (state_q == IDLE) && found;
  assign req_ready = accept ? (NUM_REQ'(1) << pick) : '0;
  assign o_tx_dv   = state_q == LAUNCH;
  assign o_busy    = state_q != IDLE;
  assign o_tx_byte = byte_q;
  assign o_grant   = grant_q;
  assign o_timeout = timeout;
`ifdef TXARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_q, wd_d;
  // watchdog: cleared at accept, counts while waiting on the transmitter
  always_comb begin
    wd_d    = wd_q;
    timeout = 1'b0;
    if (accept) wd_d = '0;
    else if (state_q == WAIT_ACTIVE || state_q == WAIT_DONE) begin
      wd_d    = wd_q + 1'b1;
      timeout = !i_tx_done && (wd_q == TW'(TIMEOUT_CYCLES - 1));
    end
  end
  // watchdog counter register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wd_q <= '0;
    else wd_q <= wd_d;
`else
  assign timeout = 1'b0;
`endif
  // next-state: accept, launch, track active/done, optional idle gap
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    byte_d       = byte_q;
    gap_d        = gap_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d      = LAUNCH;
        last_grant_d = pick;
        grant_d      = pick;
        byte_d       = req_byte[int'(pick)*8 +: 8];
      end
      LAUNCH: state_d = WAIT_ACTIVE;
      WAIT_ACTIVE, WAIT_DONE: begin
        if (i_tx_done) begin
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
          gap_d   = GW'(GAP_CYCLES - 1);
        end else if (timeout) state_d = IDLE;
        else if (state_q == WAIT_ACTIVE && i_tx_active) state_d = WAIT_DONE;
      end
      GAP: begin
        state_d = (gap_q == '0) ? IDLE : GAP;
        gap_d   = (gap_q == '0) ? gap_q : gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= IW'(NUM_REQ - 1);
      grant_q      <= '0;
      byte_q       <= '0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      byte_q       <= byte_d;
      gap_q        <= gap_d;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of the arbiter with a simple uart_tx model
module tb_uart_tx_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [1:0]  rv = '0, rdy, rv3 = '0, rdy3;
  logic [15:0] rb = '0, rb3 = '0;
  logic        dv, busy, tmo, dv3, busy3, tmo3;
  logic [7:0]  tbyte, tbyte3;
  logic        grant, grant3;
  logic        m_active = 1'b0, m_done = 1'b0, f_a = 1'b0, f_d = 1'b0, a3 = 1'b0, d3 = 1'b0;
  logic        mdl_on = 1'b1, never_done = 1'b0;
  int          m_cnt = 0, dv_cnt = 0, dn_cnt = 0, total = 0, bad = 0, c0 = 0, pulses = 0;
  wire         tx_active = m_active | f_a;
  wire         tx_done = m_done | f_d;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(2), .GAP_CYCLES(0), .TIMEOUT_CYCLES(20)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv), .req_byte(rb), .req_ready(rdy),
    .o_tx_dv(dv), .o_tx_byte(tbyte), .i_tx_active(tx_active), .i_tx_done(tx_done),
    .o_busy(busy), .o_grant(grant), .o_timeout(tmo));

  uart_tx_arbiter #(.NUM_REQ(2), .GAP_CYCLES(3), .TIMEOUT_CYCLES(20)) u3 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv3), .req_byte(rb3), .req_ready(rdy3),
    .o_tx_dv(dv3), .o_tx_byte(tbyte3), .i_tx_active(a3), .i_tx_done(d3),
    .o_busy(busy3), .o_grant(grant3), .o_timeout(tmo3));

  always @(posedge clk) begin
    m_done <= 1'b0;
    if (mdl_on && dv && !m_active) begin
      m_active <= 1'b1;
      m_cnt    <= 10;
    end else if (m_active) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_active <= 1'b0;
        m_done   <= !never_done;
      end
    end
  end

  always @(posedge clk) begin
    if (dv) dv_cnt <= dv_cnt + 1;
    if (tx_done) dn_cnt <= dn_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_dv(input string tag);
    int n = 0;
    while (!dv && n < 40) begin @(negedge clk); n++; end
    chk({tag, "_dv_wait"}, 32'(n < 40), 1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!tx_done && n < 40) begin @(negedge clk); n++; end
    chk({tag, "_done_wait"}, 32'(n < 40), 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_dv", dv, 0);
    chk("rst_byte", tbyte, 0);
    chk("rst_grant", grant, 0);
    chk("rst_tmo", tmo, 0);
    chk("rst_ready", rdy, 0);
    rv = 2'b01; rb = 16'h0041;
    @(negedge clk); rst_n = 1'b1;
    chk("t1_ready", rdy, 2'b01);
    @(negedge clk);
    chk("t1_dv", dv, 1);
    chk("t1_byte", tbyte, 8'h41);
    chk("t1_grant", grant, 0);
    chk("t1_busy", busy, 1);
    chk("t1_ready_launch", rdy, 0);
    rv = 2'b00;
    @(negedge clk);
    chk("t1_dv_once", dv, 0);
    chk("t1_byte_hold", tbyte, 8'h41);
    wait_done("t1");
    chk("t1_busy_at_done", busy, 1);
    @(negedge clk);
    chk("t1_busy_after", busy, 0);
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    rv = 2'b11; rb = 16'h3130; c0 = dv_cnt; pulses = dn_cnt;
    #1 chk("rr_ready0", rdy, 2'b01);
    for (int i = 0; i < 4; i++) begin
      wait_dv("rr");
      chk("rr_byte", tbyte, (i % 2) ? 8'h31 : 8'h30);
      chk("rr_grant", grant, i % 2);
      if (i == 3) rv = 2'b00;
      @(negedge clk);
    end
    wait_done("rr");
    @(negedge clk);
    chk("rr_dv_count", dv_cnt - c0, 4);
    chk("rr_done_count", dn_cnt - pulses, 4);
    rv3 = 2'b01; rb3 = 16'h0055;
    #1 chk("gap_ready_idle", rdy3, 2'b01);
    @(negedge clk);
    chk("gap_dv", dv3, 1);
    a3 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    a3 = 1'b0; d3 = 1'b1;
    #1 chk("gap_ready_wait", rdy3, 0);
    @(negedge clk); d3 = 1'b0;
    #1 chk("gap_ready_g1", rdy3, 0);
    chk("gap_busy", busy3, 1);
    @(negedge clk); d3 = 1'b1;
    #1 chk("gap_ready_g2", rdy3, 0);
    @(negedge clk); d3 = 1'b0;
    #1 chk("gap_ready_g3", rdy3, 0);
    chk("gap_byte_hold", tbyte3, 8'h55);
    @(negedge clk);
    chk("gap_ready_back", rdy3, 2'b01);
    chk("gap_busy_idle", busy3, 0);
    rv3 = 2'b00;
    rv = 2'b01; rb = 16'h9941;
    wait_dv("drop");
    chk("drop_byte0", tbyte, 8'h41);
    chk("drop_grant0", grant, 0);
    rv = 2'b00;
    @(negedge clk); @(negedge clk);
    rv = 2'b10;
    #1 chk("drop_ready_wd1", rdy, 0);
    @(negedge clk);
    chk("drop_ready_wd2", rdy, 0);
    @(negedge clk); rv = 2'b00;
    @(negedge clk); rv = 2'b01; rb = 16'h9942; c0 = dv_cnt;
    wait_dv("drop");
    chk("drop_byte1", tbyte, 8'h42);
    chk("drop_grant1", grant, 0);
    rv = 2'b00;
    @(negedge clk);
    chk("drop_dv_count", dv_cnt - c0, 1);
    wait_done("drop");
    @(negedge clk);
    mdl_on = 1'b0;
    rv = 2'b01; rb = 16'h0043;
    wait_dv("noact");
    chk("noact_byte", tbyte, 8'h43);
    rv = 2'b00;
    @(negedge clk); f_d = 1'b1;
    @(negedge clk); f_d = 1'b0;
    chk("noact_busy", busy, 0);
    mdl_on = 1'b1; never_done = 1'b1;
    rv = 2'b01; rb = 16'h0044;
    #1 chk("noact_ready", rdy, 2'b01);
    @(negedge clk);
    chk("wd_dv", dv, 1);
    chk("wd_byte", tbyte, 8'h44);
    rv = 2'b10; rb = 16'h4600;
`ifdef TXARB_TIMEOUT_EN
    pulses = 0;
    repeat (19) begin @(negedge clk); pulses += int'(tmo); end
    chk("wd_early", pulses, 0);
    @(negedge clk);
    chk("wd_pulse", tmo, 1);
    chk("wd_busy_pulse", busy, 1);
    @(negedge clk);
    chk("wd_pulse_once", tmo, 0);
`else
    pulses = 0;
    repeat (30) begin @(negedge clk); pulses += int'(tmo); end
    chk("wd_none", pulses, 0);
    chk("wd_still_busy", busy, 1);
    f_d = 1'b1;
    @(negedge clk); f_d = 1'b0;
`endif
    chk("wd_busy_drop", busy, 0);
    chk("wd_ready_next", rdy, 2'b10);
    @(negedge clk);
    chk("wd_next_dv", dv, 1);
    chk("wd_next_byte", tbyte, 8'h46);
    chk("wd_next_grant", grant, 1);
    rv = 2'b00;
    @(negedge clk); @(negedge clk);
    chk("mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1 chk("mid_busy", busy, 0);
    chk("mid_dv", dv, 0);
    chk("mid_grant", grant, 0);
    chk("mid_byte", tbyte, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("mid_idle", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
